layer_backward: RTL and testbench

- Backward-pass counterpart of the forward dense layer. Given the layer input, weights, forward output and upstream gradient, it produces the input gradient, weight gradient and bias gradient.
- Instances chain in reverse layer order through start/done, mirroring the forward network chain.
- Uses a single time-multiplexed MAC to bound area.

---
 rtl/layer_backward_if.sv | 29 ++
 rtl/layer_backward.sv | 196 +++++++++++++++++++
 tb/tb_layer_backward.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_backward_if.sv
// Bundle of the layer_backward data/handshake signals.
//   master : the side that launches a pass (drives start, x, y, w, dy)
//   slave  : the backward layer itself (drives dx, dw, db, busy, done)
// Vector layout: element k of an N-vector at [k*16 +: 16]; matrix element
// [i][j] of an NxN matrix at [((i*N)+j)*16 +: 16].
interface layer_backward_if #(
    parameter int N = 4
);
    logic                  start;
    logic [N*16-1:0]       x;
    logic [N*16-1:0]       y;
    logic [N*N*16-1:0]     w;
    logic [N*16-1:0]       dy;
    logic [N*16-1:0]       dx;
    logic [N*N*16-1:0]     dw;
    logic [N*16-1:0]       db;
    logic                  busy;
    logic                  done;

    modport master (
        output start, x, y, w, dy,
        input  dx, dw, db, busy, done
    );

    modport slave (
        input  start, x, y, w, dy,
        output dx, dw, db, busy, done
    );
endinterface

// File: rtl/layer_backward.sv
// Backward pass of a square dense layer (N inputs, N outputs) using one
// time-multiplexed 16x16 multiplier.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any pass in flight)
//   bus  : layer_backward_if slave modport
//          start  - one-cycle launch pulse, only honoured in IDLE
//          x,y,w,dy - forward input, forward output, weights, upstream gradient
//          dx     - dL/dx_j = sum_i W[i][j]*g_i
//          dw     - dL/dW[i][j] = g_i*x_j
//          db     - dL/db_i = g_i
//          busy   - high in LOAD, DX and DW
//          done   - one-cycle pulse once dx, dw, db are all valid
// g_i is dy_i, masked to zero where y_i <= 0 when RELU is set.
// All values are signed Q(15-FRAC).FRAC; results are shifted arithmetically
// (floor) by FRAC and saturated to 16 bits.
module layer_backward #(
    parameter int N    = 4,
    parameter int RELU = 0,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            rst,
    layer_backward_if.slave bus
);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    // Sum of N full 32-bit products plus a sign-headroom bit.
    localparam int ACCW = 32 + $clog2(N) + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DX,
        ST_DW,
        ST_FIN
    } state_t;

    state_t                 state_reg;
    logic [IW-1:0]          i_reg;
    logic [IW-1:0]          j_reg;
    logic signed [ACCW-1:0] acc_reg;
    logic                   busy_reg;
    logic                   done_reg;

    // Private copies of the operands so the caller may change inputs
    // as soon as start has been accepted.
    logic signed [15:0] x_q  [N];
    logic signed [15:0] y_q  [N];
    logic signed [15:0] dy_q [N];
    logic signed [15:0] w_q  [N][N];
    logic signed [15:0] g_reg [N];

    logic signed [15:0] dx_reg [N];
    logic signed [15:0] db_reg [N];
    logic signed [15:0] dw_reg [N][N];

    logic signed [15:0] g_next [N];

    // Shared multiplier: DX uses W[i][j]*g_i, DW uses x_j*g_i.
    logic signed [15:0]     mul_a;
    logic signed [15:0]     mul_b;
    logic signed [31:0]     mul_p;
    logic signed [ACCW-1:0] mul_ext;
    logic signed [ACCW-1:0] acc_sum;

    function automatic logic signed [15:0] sat16(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] sh;
        sh = v >>> FRAC;
        if (sh > SAT_MAX) begin
            return 16'sh7fff;
        end else if (sh < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return sh[15:0];
        end
    endfunction

    always_comb begin
        mul_a   = (state_reg == ST_DW) ? x_q[j_reg] : w_q[i_reg][j_reg];
        mul_b   = g_reg[i_reg];
        mul_p   = $signed(32'(mul_a)) * $signed(32'(mul_b));
        mul_ext = $signed(ACCW'(mul_p));
        acc_sum = acc_reg + mul_ext;
    end

    genvar gi;
    genvar gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_vec
            // ReLU derivative: zero where the forward output was not positive.
            assign g_next[gi] = ((RELU != 0) && (y_q[gi][15] || (y_q[gi] == 16'sd0)))
                                ? 16'sd0 : dy_q[gi];
            assign bus.dx[gi*16 +: 16] = dx_reg[gi];
            assign bus.db[gi*16 +: 16] = db_reg[gi];
            for (gj = 0; gj < N; gj++) begin : g_mat
                assign bus.dw[((gi*N)+gj)*16 +: 16] = dw_reg[gi][gj];
            end
        end
    endgenerate

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                x_q[k]    <= '0;
                y_q[k]    <= '0;
                dy_q[k]   <= '0;
                g_reg[k]  <= '0;
                dx_reg[k] <= '0;
                db_reg[k] <= '0;
                for (int m = 0; m < N; m++) begin
                    w_q[k][m]    <= '0;
                    dw_reg[k][m] <= '0;
                end
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < N; k++) begin
                            x_q[k]  <= bus.x[k*16 +: 16];
                            y_q[k]  <= bus.y[k*16 +: 16];
                            dy_q[k] <= bus.dy[k*16 +: 16];
                            for (int m = 0; m < N; m++) begin
                                w_q[k][m] <= bus.w[((k*N)+m)*16 +: 16];
                            end
                        end
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int k = 0; k < N; k++) begin
                        g_reg[k]  <= g_next[k];
                        db_reg[k] <= g_next[k];
                    end
                    acc_reg   <= '0;
                    i_reg     <= '0;
                    j_reg     <= '0;
                    state_reg <= ST_DX;
                end
                ST_DX: begin
                    // Column j accumulates over rows i; the final product is
                    // folded in combinationally so no extra drain cycle is needed.
                    if (i_reg == LAST) begin
                        dx_reg[j_reg] <= sat16(acc_sum);
                        acc_reg       <= '0;
                        i_reg         <= '0;
                        if (j_reg == LAST) begin
                            j_reg     <= '0;
                            state_reg <= ST_DW;
                        end else begin
                            j_reg <= j_reg + IW'(1);
                        end
                    end else begin
                        acc_reg <= acc_sum;
                        i_reg   <= i_reg + IW'(1);
                    end
                end
                ST_DW: begin
                    dw_reg[i_reg][j_reg] <= sat16(mul_ext);
                    if (j_reg == LAST) begin
                        j_reg <= '0;
                        if (i_reg == LAST) begin
                            i_reg     <= '0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_FIN;
                        end else begin
                            i_reg <= i_reg + IW'(1);
                        end
                    end else begin
                        j_reg <= j_reg + IW'(1);
                    end
                end
                ST_FIN: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_layer_backward.sv
module tb_layer_backward;
    localparam int N      = 2;
    localparam int FRAC   = 8;
    localparam int NITEMS = 2*N + N*N;   // dx[0..N-1], db[0..N-1], dw[0..N*N-1]
    localparam int LAT    = 2*N*N + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_backward_if #(.N(N)) bus_lin ();
    layer_backward_if #(.N(N)) bus_relu ();

    layer_backward #(.N(N), .RELU(0), .FRAC(FRAC)) dut_lin (
        .clk(clk), .rst(rst), .bus(bus_lin)
    );
    layer_backward #(.N(N), .RELU(1), .FRAC(FRAC)) dut_relu (
        .clk(clk), .rst(rst), .bus(bus_relu)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus currently on the bus and the model's snapshot taken at start.
    logic [15:0] sx [N];
    logic [15:0] sy [N];
    logic [15:0] sdy [N];
    logic [15:0] sw [N][N];
    int mx [N];
    int my [N];
    int mdy [N];
    int mw [N][N];

    // Observations from the most recent pass, per DUT (0 linear, 1 relu).
    int obs_lat [2];
    int obs_nbusy [2];
    int obs_ndone [2];
    logic obs_busy_after [2];

    // ---------------- reference model ----------------
    function automatic int gval(int d, int i);
        if (d == 1 && my[i] <= 0) return 0;
        return mdy[i];
    endfunction

    // floor(s / 2^FRAC) clamped to the signed 16-bit range
    function automatic logic [15:0] fix(longint s);
        longint div;
        longint q;
        div = longint'(1) << FRAC;
        q = s / div;
        if ((s % div) != 0 && s < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [15:0] exp_val(int d, int k);
        longint s;
        int i2;
        int j2;
        s = 0;
        if (k < N) begin
            for (int i = 0; i < N; i++) s += longint'(mw[i][k]) * longint'(gval(d, i));
            return fix(s);
        end else if (k < 2*N) begin
            return 16'(gval(d, k - N));
        end
        i2 = (k - 2*N) / N;
        j2 = (k - 2*N) % N;
        return fix(longint'(gval(d, i2)) * longint'(mx[j2]));
    endfunction

    function automatic logic [15:0] obs_val(int d, int k);
        if (k < N) return (d == 0) ? bus_lin.dx[k*16 +: 16] : bus_relu.dx[k*16 +: 16];
        if (k < 2*N) return (d == 0) ? bus_lin.db[(k-N)*16 +: 16] : bus_relu.db[(k-N)*16 +: 16];
        return (d == 0) ? bus_lin.dw[(k-2*N)*16 +: 16] : bus_relu.dw[(k-2*N)*16 +: 16];
    endfunction

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 2047)) - 16'd1024;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus_lin.x[i*16 +: 16]   = sx[i];   bus_relu.x[i*16 +: 16]  = sx[i];
            bus_lin.y[i*16 +: 16]   = sy[i];   bus_relu.y[i*16 +: 16]  = sy[i];
            bus_lin.dy[i*16 +: 16]  = sdy[i];  bus_relu.dy[i*16 +: 16] = sdy[i];
            for (int j = 0; j < N; j++) begin
                bus_lin.w[(i*N+j)*16 +: 16]  = sw[i][j];
                bus_relu.w[(i*N+j)*16 +: 16] = sw[i][j];
            end
        end
    endtask

    task automatic set_start(bit v);
        bus_lin.start  = v;
        bus_relu.start = v;
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < N; i++) begin
            sx[i] = rnd16(); sy[i] = rnd16(); sdy[i] = rnd16();
            for (int j = 0; j < N; j++) sw[i][j] = rnd16();
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < N; i++) begin
            mx[i] = int'($signed(sx[i]));
            my[i] = int'($signed(sy[i]));
            mdy[i] = int'($signed(sdy[i]));
            for (int j = 0; j < N; j++) mw[i][j] = int'($signed(sw[i][j]));
        end
    endtask

    // Called at a negedge. Launches a pass and watches it with a bounded loop.
    // restart_cyc: cycle (counted from the start edge) in which start is pulsed again.
    // mutate: scramble the bus inputs right after the start cycle.
    task automatic run_pass(input int restart_cyc, input bit mutate, input string tag);
        int cyc;
        snapshot();
        drive();
        set_start(1'b1);
        for (int d = 0; d < 2; d++) begin
            obs_lat[d] = 0; obs_nbusy[d] = 0; obs_ndone[d] = 0;
        end
        @(posedge clk);
        cyc = 0;
        while (cyc < 40 && (obs_lat[0] == 0 || obs_lat[1] == 0)) begin
            @(negedge clk);
            cyc++;
            set_start(cyc == restart_cyc);
            if (mutate && cyc == 1) begin
                randomize_stim();
                drive();
            end
            if (bus_lin.busy)  obs_nbusy[0]++;
            if (bus_relu.busy) obs_nbusy[1]++;
            if (bus_lin.done)  begin obs_ndone[0]++; if (obs_lat[0] == 0) obs_lat[0] = cyc; end
            if (bus_relu.done) begin obs_ndone[1]++; if (obs_lat[1] == 0) obs_lat[1] = cyc; end
        end
        @(negedge clk);
        set_start(1'b0);
        if (bus_lin.done)  obs_ndone[0]++;
        if (bus_relu.done) obs_ndone[1]++;
        obs_busy_after[0] = bus_lin.busy;
        obs_busy_after[1] = bus_relu.busy;
        $display("pass %s: lat=%0d/%0d busy=%0d/%0d dx=%h/%h db=%h/%h dw=%h/%h", tag,
                 obs_lat[0], obs_lat[1], obs_nbusy[0], obs_nbusy[1],
                 bus_lin.dx, bus_relu.dx, bus_lin.db, bus_relu.db, bus_lin.dw, bus_relu.dw);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_start(1'b1);   // start together with rst must have no effect
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (((d == 0) ? {bus_lin.dx, bus_lin.db, bus_lin.dw} : {bus_relu.dx, bus_relu.db, bus_relu.dw}) !== '0)
                $display("FAIL reset_outputs dut%0d: got nonzero outputs", d);
            else n_pass++;
            n_checks++;
            if (((d == 0) ? {bus_lin.busy, bus_lin.done} : {bus_relu.busy, bus_relu.done}) !== 2'b00)
                $display("FAIL reset_busy_done dut%0d: got %b%b want 00", d,
                         (d == 0) ? bus_lin.busy : bus_relu.busy, (d == 0) ? bus_lin.done : bus_relu.done);
            else n_pass++;
        end
        set_start(1'b0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_linear();
        sw[0][0] = 16'h0100; sw[0][1] = 16'h0200; sw[1][0] = 16'h0300; sw[1][1] = 16'h0400;
        sdy[0] = 16'h0100; sdy[1] = 16'h0100;
        sx[0] = 16'h0080;  sx[1] = 16'hFF00;
        sy[0] = 16'h0000;  sy[1] = 16'h0100;
        run_pass(0, 1'b0, "linear_relu");
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_lat[d] !== LAT) $display("FAIL linear_latency dut%0d: got %0d want %0d", d, obs_lat[d], LAT);
            else n_pass++;
            n_checks++;
            if (obs_nbusy[d] !== LAT - 1) $display("FAIL linear_busy_cycles dut%0d: got %0d want %0d", d, obs_nbusy[d], LAT - 1);
            else n_pass++;
            n_checks++;
            if (obs_ndone[d] !== 1) $display("FAIL linear_done_pulses dut%0d: got %0d want 1", d, obs_ndone[d]);
            else n_pass++;
            for (int k = 0; k < NITEMS; k++) begin
                n_checks++;
                if (obs_val(d, k) !== exp_val(d, k))
                    $display("FAIL linear_item dut%0d k%0d: got %h want %h", d, k, obs_val(d, k), exp_val(d, k));
                else n_pass++;
            end
        end
        n_checks++;
        if ({bus_lin.dx, bus_lin.db, bus_lin.dw} !== {32'h0600_0400, 32'h0100_0100, 64'hFF00_0080_FF00_0080})
            $display("FAIL linear_const: got %h %h %h", bus_lin.dx, bus_lin.db, bus_lin.dw);
        else n_pass++;
        n_checks++;
        if ({bus_relu.dx, bus_relu.db, bus_relu.dw} !== {32'h0400_0300, 32'h0100_0000, 64'hFF00_0080_0000_0000})
            $display("FAIL relu_const: got %h %h %h", bus_relu.dx, bus_relu.db, bus_relu.dw);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) sw[i][j] = 16'h7F00;
        sdy[0] = 16'h7F00; sdy[1] = 16'h7F00;
        sx[0] = 16'h8000;  sx[1] = 16'h7F00;
        sy[0] = 16'h0100;  sy[1] = 16'h0100;
        run_pass(0, 1'b0, "saturation");
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NITEMS; k++) begin
                n_checks++;
                if (obs_val(d, k) !== exp_val(d, k))
                    $display("FAIL sat_item dut%0d k%0d: got %h want %h", d, k, obs_val(d, k), exp_val(d, k));
                else n_pass++;
            end
        end
        n_checks++;
        if ({bus_lin.dx, bus_lin.dw} !== {32'h7FFF_7FFF, 64'h7FFF_8000_7FFF_8000})
            $display("FAIL sat_const: got %h %h", bus_lin.dx, bus_lin.dw);
        else n_pass++;
    endtask

    task automatic test_truncation();
        sw[0][0] = 16'h0001; sw[0][1] = 16'h0000; sw[1][0] = 16'h0000; sw[1][1] = 16'h0000;
        sdy[0] = 16'hFFFF; sdy[1] = 16'h0000;
        sx[0] = 16'h0001;  sx[1] = 16'h0000;
        sy[0] = 16'h0100;  sy[1] = 16'h0100;
        run_pass(0, 1'b0, "truncation");
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NITEMS; k++) begin
                n_checks++;
                if (obs_val(d, k) !== exp_val(d, k))
                    $display("FAIL trunc_item dut%0d k%0d: got %h want %h", d, k, obs_val(d, k), exp_val(d, k));
                else n_pass++;
            end
        end
        n_checks++;
        if ({bus_lin.dx[15:0], bus_lin.dw[15:0]} !== 32'hFFFF_FFFF)
            $display("FAIL trunc_const: got dx0=%h dw00=%h want ffff ffff", bus_lin.dx[15:0], bus_lin.dw[15:0]);
        else n_pass++;
    endtask

    // Extra start during the pass (restart_cyc) plus input changes after start.
    task automatic test_protocol(input int restart_cyc, input string tag);
        randomize_stim();
        run_pass(restart_cyc, 1'b1, tag);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_lat[d] !== LAT) $display("FAIL %s_latency dut%0d: got %0d want %0d", tag, d, obs_lat[d], LAT);
            else n_pass++;
            n_checks++;
            if (obs_ndone[d] !== 1) $display("FAIL %s_done_pulses dut%0d: got %0d want 1", tag, d, obs_ndone[d]);
            else n_pass++;
            n_checks++;
            if (obs_busy_after[d] !== 1'b0) $display("FAIL %s_busy_after dut%0d: got %b want 0", tag, d, obs_busy_after[d]);
            else n_pass++;
            for (int k = 0; k < NITEMS; k++) begin
                n_checks++;
                if (obs_val(d, k) !== exp_val(d, k))
                    $display("FAIL %s_item dut%0d k%0d: got %h want %h", tag, d, k, obs_val(d, k), exp_val(d, k));
                else n_pass++;
            end
        end
    endtask

    // Second pass launched in the cycle right after the done pulse.
    task automatic test_back_to_back();
        for (int p = 0; p < 2; p++) begin
            randomize_stim();
            run_pass(0, 1'b0, "back_to_back");
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs_lat[d] !== LAT) $display("FAIL b2b_latency dut%0d p%0d: got %0d want %0d", d, p, obs_lat[d], LAT);
                else n_pass++;
                for (int k = 0; k < NITEMS; k++) begin
                    n_checks++;
                    if (obs_val(d, k) !== exp_val(d, k))
                        $display("FAIL b2b_item dut%0d p%0d k%0d: got %h want %h", d, p, k, obs_val(d, k), exp_val(d, k));
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        randomize_stim();
        snapshot();
        drive();
        set_start(1'b1);
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            set_start(1'b0);
        end
        @(negedge clk);          // 4th DX cycle
        rst = 1'b1;
        set_start(1'b1);         // rst wins over a simultaneous start
        @(negedge clk);
        rst = 1'b0;
        set_start(1'b0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (((d == 0) ? {bus_lin.dx, bus_lin.db, bus_lin.dw} : {bus_relu.dx, bus_relu.db, bus_relu.dw}) !== '0)
                $display("FAIL midreset_outputs dut%0d: got nonzero outputs", d);
            else n_pass++;
            n_checks++;
            if (((d == 0) ? {bus_lin.busy, bus_lin.done} : {bus_relu.busy, bus_relu.done}) !== 2'b00)
                $display("FAIL midreset_busy_done dut%0d: got %b%b want 00", d,
                         (d == 0) ? bus_lin.busy : bus_relu.busy, (d == 0) ? bus_lin.done : bus_relu.done);
            else n_pass++;
        end
        ndone = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus_lin.done || bus_relu.done || bus_lin.busy || bus_relu.busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL midreset_quiet: got %0d active cycles want 0", ndone);
        else n_pass++;
        $display("pass reset_mid: aborted, outputs cleared");
        randomize_stim();
        run_pass(0, 1'b0, "after_reset");
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_lat[d] !== LAT) $display("FAIL after_reset_latency dut%0d: got %0d want %0d", d, obs_lat[d], LAT);
            else n_pass++;
            for (int k = 0; k < NITEMS; k++) begin
                n_checks++;
                if (obs_val(d, k) !== exp_val(d, k))
                    $display("FAIL after_reset_item dut%0d k%0d: got %h want %h", d, k, obs_val(d, k), exp_val(d, k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            randomize_stim();
            run_pass(0, 1'b0, "random");
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs_lat[d] !== LAT) $display("FAIL rand_latency dut%0d p%0d: got %0d want %0d", d, p, obs_lat[d], LAT);
                else n_pass++;
                for (int k = 0; k < NITEMS; k++) begin
                    n_checks++;
                    if (obs_val(d, k) !== exp_val(d, k))
                        $display("FAIL rand_item dut%0d p%0d k%0d: got %h want %h", d, p, k, obs_val(d, k), exp_val(d, k));
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        set_start(1'b0);
        for (int i = 0; i < N; i++) begin
            sx[i] = '0; sy[i] = '0; sdy[i] = '0;
            for (int j = 0; j < N; j++) sw[i][j] = '0;
        end
        drive();
        test_reset();
        test_linear();
        test_saturation();
        test_truncation();
        test_protocol(3, "restart_busy");
        test_protocol(LAT, "restart_fin");
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
